// File: rtl/fp_add_seq_if.sv
// Command/result bundle for fp_add_seq: start with operands and sub in, and busy/done/result/ovf/unf out.
// The master side drives operands and start; the slave side (the sequencer) returns status and result.
interface fp_add_seq_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        ovf;
    logic        unf;

    modport master (output start, a, b, sub, input busy, done, result, ovf, unf);
    modport slave  (input start, a, b, sub, output busy, done, result, ovf, unf);
endinterface

// File: rtl/fp_add_seq.sv
// Multi-cycle binary32 add/subtract: truncating alignment, bit-serial normalize, no denormals/NaN; latency d+n+3 cycles.
// No backpressure: one operation in flight, start is ignored unless IDLE; result/ovf/unf hold until the next op finishes.
module fp_add_seq (
    input  logic        clk,
    input  logic        rst_n,
    fp_add_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

    state_t      state_q, state_d;
    logic [23:0] mant_big_q, mant_big_d;
    logic [23:0] mant_sml_q, mant_sml_d;
    logic        sign_big_q, sign_big_d;
    logic        sign_sml_q, sign_sml_d;
    logic [9:0]  exp_q, exp_d;
    logic [4:0]  shift_q, shift_d;
    logic [24:0] sum_q, sum_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] result_q, result_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;

    logic [7:0]  exp_a, exp_b, exp_diff;
    logic [23:0] mant_a, mant_b;
    logic        sign_b_eff;
    logic        a_big;

    assign exp_a      = bus.a[30:23];
    assign exp_b      = bus.b[30:23];
    assign mant_a     = (exp_a == 8'd0) ? 24'd0 : {1'b1, bus.a[22:0]};
    assign mant_b     = (exp_b == 8'd0) ? 24'd0 : {1'b1, bus.b[22:0]};
    assign sign_b_eff = bus.b[31] ^ bus.sub;
    // Magnitude order on {exp, fraction}; ties keep A as the big operand.
    assign a_big      = bus.a[30:0] >= bus.b[30:0];
    assign exp_diff   = a_big ? (exp_a - exp_b) : (exp_b - exp_a);

    always_comb begin
        state_d    = state_q;
        mant_big_d = mant_big_q;
        mant_sml_d = mant_sml_q;
        sign_big_d = sign_big_q;
        sign_sml_d = sign_sml_q;
        exp_d      = exp_q;
        shift_d    = shift_q;
        sum_d      = sum_q;
        result_d   = result_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mant_big_d = a_big ? mant_a : mant_b;
                    mant_sml_d = a_big ? mant_b : mant_a;
                    sign_big_d = a_big ? bus.a[31] : sign_b_eff;
                    sign_sml_d = a_big ? sign_b_eff : bus.a[31];
                    exp_d      = {2'b00, (a_big ? exp_a : exp_b)};
                    shift_d    = (exp_diff > 8'd25) ? 5'd25 : exp_diff[4:0];
                    state_d    = (exp_diff == 8'd0) ? ADD : ALIGN;
                end
            end
            ALIGN: begin
                mant_sml_d = mant_sml_q >> 1;
                shift_d    = shift_q - 5'd1;
                if (shift_q == 5'd1) state_d = ADD;
            end
            ADD: begin
                // Ordering guarantees big >= small, so the difference never wraps.
                if (sign_big_q != sign_sml_q)
                    sum_d = {1'b0, mant_big_q} - {1'b0, mant_sml_q};
                else
                    sum_d = {1'b0, mant_big_q} + {1'b0, mant_sml_q};
                state_d = NORM;
            end
            NORM: begin
                if (sum_q == 25'd0) begin
                    result_d = 32'h0000_0000;
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    state_d  = DONE;
                end else if (sum_q[24]) begin
                    sum_d = sum_q >> 1;
                    exp_d = exp_q + 10'd1;
                end else if (!sum_q[23]) begin
                    if (exp_q <= 10'd1) begin
                        result_d = 32'h0000_0000;
                        ovf_d    = 1'b0;
                        unf_d    = 1'b1;
                        state_d  = DONE;
                    end else begin
                        sum_d = sum_q << 1;
                        exp_d = exp_q - 10'd1;
                    end
                end else begin
                    ovf_d    = (exp_q >= 10'd255);
                    unf_d    = 1'b0;
                    result_d = (exp_q >= 10'd255) ? {sign_big_q, 8'hFF, 23'd0}
                                                  : {sign_big_q, exp_q[7:0], sum_q[22:0]};
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mant_big_q <= '0;
            mant_sml_q <= '0;
            sign_big_q <= 1'b0;
            sign_sml_q <= 1'b0;
            exp_q      <= '0;
            shift_q    <= '0;
            sum_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mant_big_q <= mant_big_d;
            mant_sml_q <= mant_sml_d;
            sign_big_q <= sign_big_d;
            sign_sml_q <= sign_sml_d;
            exp_q      <= exp_d;
            shift_q    <= shift_d;
            sum_q      <= sum_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.ovf    = ovf_q;
    assign bus.unf    = unf_q;
endmodule
